// File: rtl/serial_adder_ctrl.sv
// serial_adder_ctrl: bit-serial WIDTH-bit adder built around one Full_Adder cell.
// Operands and carry-in are captured on a start handshake and processed LSB-first,
// one bit per clock. The registered {Cout,Sum} is published with a one-cycle done pulse.

// Full_Adder: 1-bit full adder cell, purely combinational.
module Full_Adder (
  input  logic a,
  input  logic b,
  input  logic cin,
  output logic sum,
  output logic cout
);

  assign sum  = a ^ b ^ cin;
  assign cout = (a & b) | (cin & (a ^ b));

endmodule

module serial_adder_ctrl #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic             Cin,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] Sum,
  output logic             Cout
);

  // Bit counter spans 0..WIDTH-1; the last bit is processed when it equals WIDTH-1.
  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0] LAST_BIT = CW'(WIDTH - 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t state_reg;
  state_t state_next;

  logic [WIDTH-1:0] a_sh_reg;
  logic [WIDTH-1:0] b_sh_reg;
  // Only WIDTH-1 partial sum bits ever need storing: the final bit comes straight
  // from the full adder on the completion edge.
  logic [WIDTH-2:0] res_sh_reg;
  logic [WIDTH-2:0] res_sh_next;
  logic             carry_reg;
  logic [CW-1:0]    cnt_reg;
  logic [WIDTH-1:0] sum_reg;
  logic             cout_reg;

  logic fa_sum;
  logic fa_cout;
  logic last_bit;

  Full_Adder u_fa (
    .a    (a_sh_reg[0]),
    .b    (b_sh_reg[0]),
    .cin  (carry_reg),
    .sum  (fa_sum),
    .cout (fa_cout)
  );

  assign last_bit = (cnt_reg == LAST_BIT);

  // Partial result shifts right with the new sum bit entering at the top.
  genvar gi;
  generate
    for (gi = 0; gi < WIDTH - 2; gi++) begin : g_res_shift
      assign res_sh_next[gi] = res_sh_reg[gi+1];
    end
  endgenerate
  assign res_sh_next[WIDTH-2] = fa_sum;

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg <= S_IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  // Next-state logic: start only matters in IDLE, DONE always lasts one cycle.
  always_comb begin
    state_next = state_reg;
    case (state_reg)
      S_IDLE:  if (start) state_next = S_RUN;
      S_RUN:   if (last_bit) state_next = S_DONE;
      S_DONE:  state_next = S_IDLE;
      default: state_next = S_IDLE;
    endcase
  end

  // Status outputs decoded from the registered state only.
  always_comb begin
    busy = (state_reg == S_RUN);
    done = (state_reg == S_DONE);
  end

  // Datapath: operand capture, per-bit shifting, and result publication.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_sh_reg   <= '0;
      b_sh_reg   <= '0;
      res_sh_reg <= '0;
      carry_reg  <= 1'b0;
      cnt_reg    <= '0;
      sum_reg    <= '0;
      cout_reg   <= 1'b0;
    end else begin
      case (state_reg)
        S_IDLE: begin
          if (start) begin
            a_sh_reg   <= A;
            b_sh_reg   <= B;
            res_sh_reg <= '0;
            carry_reg  <= Cin;
            cnt_reg    <= '0;
          end
        end
        S_RUN: begin
          a_sh_reg   <= {1'b0, a_sh_reg[WIDTH-1:1]};
          b_sh_reg   <= {1'b0, b_sh_reg[WIDTH-1:1]};
          res_sh_reg <= res_sh_next;
          carry_reg  <= fa_cout;
          cnt_reg    <= cnt_reg + CW'(1);
          if (last_bit) begin
            sum_reg  <= {fa_sum, res_sh_reg};
            cout_reg <= fa_cout;
          end
        end
        default: begin
        end
      endcase
    end
  end

  assign Sum  = sum_reg;
  assign Cout = cout_reg;

endmodule
